// File: rtl/svm_pkg.sv
// Shared types and helpers for the multi-class linear SVM scorer.
package svm_pkg;

  localparam int FEA_I_DEFAULT = 4;
  localparam int FEA_F_DEFAULT = 12;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/svm_coef_ram.sv
// Per-class coefficient banks: one write port (selects a class), one registered read of all classes.
module svm_coef_ram #(
  parameter int N_CLASS = 2,
  parameter int N_FEA   = 3780,
  parameter int FEA_W   = 16,
  parameter int ADDR_W  = 12,
  parameter int CLS_W   = 1
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [CLS_W-1:0]           wclass,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [FEA_W-1:0]           wdata,
  input  logic                       re,
  input  logic [ADDR_W-1:0]          raddr,
  output logic [N_CLASS*FEA_W-1:0]   rdata
);

  for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_bank
    logic [FEA_W-1:0] mem [N_FEA];
    logic [FEA_W-1:0] rd_reg;

    always_ff @(posedge clk) begin
      if (we && wclass == CLS_W'(gi)) mem[waddr] <= wdata;
      if (re) rd_reg <= mem[raddr];
    end

    assign rdata[gi*FEA_W +: FEA_W] = rd_reg;
  end

endmodule

// File: rtl/svm_mc_classifier.sv
// Streams one HOG feature per cycle, dot-products it against N_CLASS coefficient sets,
// and emits saturated per-class scores, argmax class and threshold decision per window.
module svm_mc_classifier
  import svm_pkg::*;
#(
  parameter int FEA_I   = FEA_I_DEFAULT,
  parameter int FEA_F   = FEA_F_DEFAULT,
  parameter int N_FEA   = 3780,
  parameter int N_CLASS = 2,
  parameter int SW_W    = 11,
  localparam int FEA_W  = FEA_I + FEA_F,
  localparam int ADDR_W = $clog2(N_FEA),
  localparam int CLS_W  = (N_CLASS > 1) ? $clog2(N_CLASS) : 1,
  localparam int ACC_W  = 2*FEA_W + $clog2(N_FEA)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [CLS_W-1:0]         cfg_class,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [FEA_W-1:0]         cfg_data,
  input  logic                     b_load,
  input  logic [CLS_W-1:0]         b_class,
  input  logic [FEA_W-1:0]         bias,
  input  logic [FEA_W-1:0]         thr,
  output logic                     cfg_err,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [FEA_W-1:0]         fea,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [N_CLASS*FEA_W-1:0] o_score,
  output logic [CLS_W-1:0]         o_class,
  output logic                     is_person,
  output logic [SW_W-1:0]          sw_id
);

  state_t state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg;
  logic [SW_W-1:0] sw_cnt_reg;
  logic accept, advance, last_idx;
  logic cfg_window, coef_we, bias_we;
  logic [N_CLASS*FEA_W-1:0] coef_rd;
  logic [N_CLASS*FEA_W-1:0] sat_flat;
  logic signed [FEA_W-1:0] fea_reg;
  logic v1_reg, first1_reg, last1_reg;
  logic v2_reg, first2_reg, last2_reg;
  logic done3_reg, done4_reg;
  logic [CLS_W-1:0] best_idx;
  logic signed [FEA_W-1:0] best_val;

  // A pending unconsumed result freezes every pipeline stage.
  assign advance  = !o_valid || o_ready;
  assign i_ready  = (state_reg != DRAIN) && advance;
  assign accept   = i_valid && i_ready;
  assign last_idx = (idx_reg == ADDR_W'(N_FEA - 1));

  assign cfg_window = (state_reg == IDLE) && !accept;
  assign coef_we = cfg_we && cfg_window && (int'(cfg_addr) < N_FEA) && (int'(cfg_class) < N_CLASS);
  assign bias_we = b_load && cfg_window && (int'(b_class) < N_CLASS);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (accept) state_next = last_idx ? DRAIN : RUN;
      RUN:     if (accept && last_idx) state_next = DRAIN;
      DRAIN:   if (advance && done4_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  svm_coef_ram #(
    .N_CLASS(N_CLASS), .N_FEA(N_FEA), .FEA_W(FEA_W), .ADDR_W(ADDR_W), .CLS_W(CLS_W)
  ) u_coef_ram (
    .clk(clk), .we(coef_we), .wclass(cfg_class), .waddr(cfg_addr), .wdata(cfg_data),
    .re(accept), .raddr(idx_reg), .rdata(coef_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg    <= '0;
      v1_reg     <= 1'b0;
      first1_reg <= 1'b0;
      last1_reg  <= 1'b0;
      v2_reg     <= 1'b0;
      first2_reg <= 1'b0;
      last2_reg  <= 1'b0;
      done3_reg  <= 1'b0;
      done4_reg  <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= (cfg_we && !coef_we) || (b_load && !bias_we);
      if (advance) begin
        v1_reg <= accept;
        if (accept) begin
          fea_reg    <= fea;
          first1_reg <= (idx_reg == '0);
          last1_reg  <= last_idx;
          idx_reg    <= last_idx ? '0 : idx_reg + 1'b1;
        end
        v2_reg     <= v1_reg;
        first2_reg <= first1_reg;
        last2_reg  <= last1_reg;
        done3_reg  <= v2_reg && last2_reg;
        done4_reg  <= done3_reg;
      end
    end
  end

  for (genvar gi = 0; gi < N_CLASS; gi++) begin : g_class
    logic signed [FEA_W-1:0]   coef_c;
    logic signed [FEA_W-1:0]   bias_reg;
    logic signed [2*FEA_W-1:0] prod_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic signed [FEA_W-1:0]   sat_reg;
    logic signed [ACC_W:0]     total;
    logic signed [63:0]        shifted;

    assign coef_c  = coef_rd[gi*FEA_W +: FEA_W];
    // Bias is in feature units; align it to the Q(2*FEA_F) product scale before adding.
    assign total   = (ACC_W+1)'(acc_reg) + ((ACC_W+1)'(bias_reg) <<< FEA_F);
    assign shifted = 64'(total >>> FEA_F);

    always_ff @(posedge clk) begin
      if (bias_we && b_class == CLS_W'(gi)) bias_reg <= bias;
      if (!rst && advance) begin
        if (v1_reg)    prod_reg <= (2*FEA_W)'(fea_reg) * (2*FEA_W)'(coef_c);
        if (v2_reg)    acc_reg  <= first2_reg ? ACC_W'(prod_reg) : acc_reg + ACC_W'(prod_reg);
        if (done3_reg) sat_reg  <= FEA_W'(saturate(shifted, FEA_W));
      end
    end

    assign sat_flat[gi*FEA_W +: FEA_W] = sat_reg;
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    best_idx = '0;
    best_val = $signed(sat_flat[FEA_W-1:0]);
    for (int c = 1; c < N_CLASS; c++) begin
      if ($signed(sat_flat[c*FEA_W +: FEA_W]) > best_val) begin
        best_val = $signed(sat_flat[c*FEA_W +: FEA_W]);
        best_idx = CLS_W'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_score    <= '0;
      o_class    <= '0;
      is_person  <= 1'b0;
      sw_id      <= '0;
      sw_cnt_reg <= '0;
    end else if (advance) begin
      o_valid <= done4_reg;
      if (done4_reg) begin
        o_score    <= sat_flat;
        o_class    <= best_idx;
        is_person  <= best_val > $signed(thr);
        sw_id      <= sw_cnt_reg;
        sw_cnt_reg <= sw_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_svm_mc_classifier.sv
// Directed bench for svm_mc_classifier with N_FEA=4, N_CLASS=2, SW_W=2.
module tb_svm_mc_classifier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [0:0]  cfg_class = '0;
  logic [1:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        b_load = 1'b0;
  logic [0:0]  b_class = '0;
  logic [15:0] bias = '0;
  logic [15:0] thr = '0;
  logic        cfg_err;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [15:0] fea = '0;
  logic        o_valid;
  logic        o_ready = 1'b1;
  logic [31:0] o_score;
  logic [0:0]  o_class;
  logic        is_person;
  logic [1:0]  sw_id;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_acc = 0;
  int res_cyc = 0;

  svm_mc_classifier #(
    .FEA_I(4), .FEA_F(12), .N_FEA(4), .N_CLASS(2), .SW_W(2)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_class(cfg_class), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .b_load(b_load), .b_class(b_class), .bias(bias), .thr(thr),
    .cfg_err(cfg_err), .i_valid(i_valid), .i_ready(i_ready), .fea(fea),
    .o_valid(o_valid), .o_ready(o_ready), .o_score(o_score), .o_class(o_class),
    .is_person(is_person), .sw_id(sw_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic write_coef(input int c, input int a, input logic [15:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_class = 1'(c); cfg_addr = 2'(a); cfg_data = d;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic write_bias(input int c, input logic [15:0] d);
    @(negedge clk);
    b_load = 1'b1; b_class = 1'(c); bias = d;
    @(posedge clk);
    #1;
    b_load = 1'b0;
  endtask

  task automatic load_class(input int c, input logic [15:0] d);
    for (int a = 0; a < 4; a++) write_coef(c, a, d);
  endtask

  task automatic send(input logic [15:0] v);
    int n;
    @(negedge clk);
    i_valid = 1'b1;
    fea = v;
    n = 0;
    while (!i_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    last_acc = cyc;
  endtask

  task automatic send4(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    send(a); send(b); send(c); send(d);
  endtask

  task automatic wait_result(output bit got);
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        got = 1'b1;
        res_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    tests++; if (o_score !== 32'h0) begin fails++; $display("FAIL reset_o_score got %h want 0", o_score); end
    tests++; if (o_class !== 1'b0) begin fails++; $display("FAIL reset_o_class got %h want 0", o_class); end
    tests++; if (is_person !== 1'b0) begin fails++; $display("FAIL reset_is_person got %b want 0", is_person); end
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL reset_cfg_err got %b want 0", cfg_err); end
    tests++; if (sw_id !== 2'd0) begin fails++; $display("FAIL reset_sw_id got %0d want 0", sw_id); end
    tests++; if (i_ready !== 1'b1) begin fails++; $display("FAIL reset_i_ready got %b want 1", i_ready); end
    $display("[TB] reset checked");
  endtask

  task automatic test_basic();
    bit got;
    load_class(0, 16'h1000);
    load_class(1, 16'hF000);
    write_bias(0, 16'h0000);
    write_bias(1, 16'h0000);
    thr = 16'h2000;
    send4(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    wait_result(got);
    tests++; if (!got) begin fails++; $display("FAIL basic_result_timeout got none want o_valid"); end
    tests++; if (res_cyc - last_acc != 4) begin fails++; $display("FAIL basic_latency got %0d want 4", res_cyc - last_acc); end
    tests++; if (o_score !== 32'hC000_4000) begin fails++; $display("FAIL basic_score got %h want c0004000", o_score); end
    tests++; if (o_class !== 1'b0) begin fails++; $display("FAIL basic_class got %0d want 0", o_class); end
    tests++; if (is_person !== 1'b1) begin fails++; $display("FAIL basic_is_person got %b want 1", is_person); end
    tests++; if (sw_id !== 2'd0) begin fails++; $display("FAIL basic_sw_id got %0d want 0", sw_id); end
    @(posedge clk); #1;
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL basic_o_valid_drop got %b want 0", o_valid); end
    $display("[TB] basic score=%h class=%0d person=%b sw_id=%0d", o_score, o_class, is_person, sw_id);
  endtask

  task automatic test_saturation();
    bit got;
    load_class(0, 16'h7FFF);
    load_class(1, 16'h8000);
    thr = 16'h7FFF;
    send4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    wait_result(got);
    tests++; if (!got) begin fails++; $display("FAIL sat_result_timeout got none want o_valid"); end
    tests++; if (o_score !== 32'h8000_7FFF) begin fails++; $display("FAIL sat_score got %h want 80007fff", o_score); end
    tests++; if (o_class !== 1'b0) begin fails++; $display("FAIL sat_class got %0d want 0", o_class); end
    tests++; if (is_person !== 1'b0) begin fails++; $display("FAIL sat_is_person_strict got %b want 0", is_person); end
    tests++; if (sw_id !== 2'd1) begin fails++; $display("FAIL sat_sw_id got %0d want 1", sw_id); end
    $display("[TB] saturation score=%h class=%0d person=%b sw_id=%0d", o_score, o_class, is_person, sw_id);
  endtask

  task automatic test_stall();
    bit got;
    int hs;
    load_class(0, 16'h1000);
    load_class(1, 16'h2000);
    write_bias(0, 16'h1000);
    write_bias(1, 16'hF000);
    thr = 16'h4000;
    o_ready = 1'b0;
    send4(16'h1000, 16'h2000, 16'hF000, 16'h0800);
    wait_result(got);
    tests++; if (!got) begin fails++; $display("FAIL stall_result_timeout got none want o_valid"); end
    tests++; if (o_score !== 32'h4000_3800) begin fails++; $display("FAIL stall_score got %h want 40003800", o_score); end
    tests++; if (o_class !== 1'b1) begin fails++; $display("FAIL stall_class got %0d want 1", o_class); end
    tests++; if (is_person !== 1'b0) begin fails++; $display("FAIL stall_is_person got %b want 0", is_person); end
    tests++; if (sw_id !== 2'd2) begin fails++; $display("FAIL stall_sw_id got %0d want 2", sw_id); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      tests++;
      if (o_valid !== 1'b1 || o_score !== 32'h4000_3800 || i_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold cycle %0d got v=%b s=%h rdy=%b want v=1 s=40003800 rdy=0",
                 i, o_valid, o_score, i_ready);
      end
    end
    @(negedge clk);
    o_ready = 1'b1;
    hs = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (o_valid && o_ready) hs++;
      @(negedge clk);
    end
    tests++; if (hs != 1) begin fails++; $display("FAIL stall_handshakes got %0d want 1", hs); end
    $display("[TB] stall handshakes=%0d", hs);
  endtask

  task automatic test_cfg_reject();
    bit got;
    logic [15:0] fv [4];
    fv[0] = 16'h1000; fv[1] = 16'h2000; fv[2] = 16'hF000; fv[3] = 16'h0800;
    write_coef(0, 0, 16'h1000);
    tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL cfg_idle_err got %b want 0", cfg_err); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i_valid = 1'b1;
      fea = fv[i];
      if (i == 2) begin
        cfg_we = 1'b1; cfg_class = 1'b0; cfg_addr = 2'd1; cfg_data = 16'h7FFF;
      end
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (i == 2) begin
        tests++; if (cfg_err !== 1'b1) begin fails++; $display("FAIL cfg_run_err_pulse got %b want 1", cfg_err); end
      end
      if (i == 3) begin
        tests++; if (cfg_err !== 1'b0) begin fails++; $display("FAIL cfg_run_err_single got %b want 0", cfg_err); end
      end
    end
    i_valid = 1'b0;
    wait_result(got);
    tests++; if (!got) begin fails++; $display("FAIL cfg_result_timeout got none want o_valid"); end
    tests++; if (o_score !== 32'h4000_3800) begin fails++; $display("FAIL cfg_repeat_score got %h want 40003800", o_score); end
    tests++; if (sw_id !== 2'd3) begin fails++; $display("FAIL cfg_sw_id got %0d want 3", sw_id); end
    $display("[TB] cfg reject score=%h sw_id=%0d", o_score, sw_id);
  endtask

  task automatic test_reset_mid();
    bit got;
    int extra;
    send(16'h7FFF);
    send(16'h7FFF);
    do_reset();
    tests++; if (i_ready !== 1'b1 || o_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_state got rdy=%b v=%b want rdy=1 v=0", i_ready, o_valid); end
    send4(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    wait_result(got);
    tests++; if (!got) begin fails++; $display("FAIL mid_result_timeout got none want o_valid"); end
    tests++; if (o_score !== 32'h7000_5000) begin fails++; $display("FAIL mid_score got %h want 70005000", o_score); end
    tests++; if (o_class !== 1'b1 || is_person !== 1'b1) begin fails++; $display("FAIL mid_class_person got %0d/%b want 1/1", o_class, is_person); end
    tests++; if (sw_id !== 2'd0) begin fails++; $display("FAIL mid_sw_id got %0d want 0", sw_id); end
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (o_valid) extra++;
    end
    tests++; if (extra != 0) begin fails++; $display("FAIL mid_extra_results got %0d want 0", extra); end
    $display("[TB] reset mid-window score=%h sw_id=%0d", o_score, sw_id);
  endtask

  task automatic test_back_to_back();
    bit got;
    do_reset();
    load_class(0, 16'h0800);
    load_class(1, 16'h0800);
    write_bias(0, 16'h0000);
    write_bias(1, 16'h0000);
    thr = 16'h2000;
    for (int w = 0; w < 5; w++) begin
      send4(16'h1000, 16'h1000, 16'h1000, 16'h1000);
      wait_result(got);
      tests++;
      if (!got || sw_id !== 2'(w % 4) || o_score !== 32'h2000_2000 || o_class !== 1'b0 || is_person !== 1'b0) begin
        fails++;
        $display("FAIL b2b window %0d got v=%b id=%0d s=%h c=%0d p=%b want v=1 id=%0d s=20002000 c=0 p=0",
                 w, got, sw_id, o_score, o_class, is_person, w % 4);
      end
      $display("[TB] window %0d sw_id=%0d score=%h class=%0d", w, sw_id, o_score, o_class);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_stall();
    test_cfg_reject();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
